// File: rtl/acc_alu_seq.sv
// Accumulator/ALU for the hardwired CPU datapath: owns AC, E and MQ, runs
// single-cycle ops, multi-cycle N-step circulates and a shift-add multiply.
module acc_alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] dr,
    input  logic [WIDTH-1:0] inpr,
    output logic [WIDTH-1:0] ac,
    output logic             e,
    output logic [WIDTH-1:0] mq,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             zero,
    output logic             neg
);

    // Counter must hold both a full rotate count and the multiply step count.
    localparam int unsigned MUL_CW = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W  = (CW > MUL_CW) ? CW : MUL_CW;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_LDA = 4'd2;
    localparam logic [3:0] OP_INP = 4'd3;
    localparam logic [3:0] OP_CMA = 4'd4;
    localparam logic [3:0] OP_CIR = 4'd5;
    localparam logic [3:0] OP_CIL = 4'd6;
    localparam logic [3:0] OP_INC = 4'd7;
    localparam logic [3:0] OP_CLA = 4'd8;
    localparam logic [3:0] OP_CLE = 4'd9;
    localparam logic [3:0] OP_CME = 4'd10;
    localparam logic [3:0] OP_RORN = 4'd11;
    localparam logic [3:0] OP_ROLN = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_MUL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   ac_q, ac_d;
    logic               e_q, e_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ror_q, ror_d;
    logic [WIDTH-1:0]   mul_m_q, mul_m_d;
    logic [WIDTH-1:0]   mul_p_q, mul_p_d;
    logic [WIDTH-1:0]   mul_r_q, mul_r_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     mul_sum;
    logic [CW-1:0]      rot_n;
    logic [WIDTH-1:0]   mul_p_nxt;
    logic [WIDTH-1:0]   mul_r_nxt;

    assign add_sum   = {1'b0, ac_q} + {1'b0, dr};
    assign mul_sum   = {1'b0, mul_p_q} + (mul_r_q[0] ? {1'b0, mul_m_q} : '0);
    assign mul_p_nxt = mul_sum[WIDTH:1];
    assign mul_r_nxt = {mul_sum[0], mul_r_q[WIDTH-1:1]};
    assign rot_n     = dr[CW-1:0];

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ac_d      = ac_q;
        e_d       = e_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        ror_d     = ror_q;
        mul_m_d   = mul_m_q;
        mul_p_d   = mul_p_q;
        mul_r_d   = mul_r_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    case (op)
                        OP_AND: ac_d = ac_q & dr;
                        OP_ADD: {e_d, ac_d} = add_sum;
                        OP_LDA: ac_d = dr;
                        OP_INP: ac_d = inpr;
                        OP_CMA: ac_d = ~ac_q;
                        OP_CIR: begin
                            ac_d = {e_q, ac_q[WIDTH-1:1]};
                            e_d  = ac_q[0];
                        end
                        OP_CIL: begin
                            ac_d = {ac_q[WIDTH-2:0], e_q};
                            e_d  = ac_q[WIDTH-1];
                        end
                        OP_INC: ac_d = ac_q + WIDTH'(1);
                        OP_CLA: ac_d = '0;
                        OP_CLE: e_d = 1'b0;
                        OP_CME: e_d = ~e_q;
                        OP_RORN, OP_ROLN: begin
                            ror_d = (op == OP_RORN);
                            if (rot_n != '0) begin
                                done_d  = 1'b0;
                                cnt_d   = CNT_W'(rot_n);
                                state_d = S_ROT;
                            end
                        end
                        OP_MUL: begin
                            done_d  = 1'b0;
                            mul_m_d = ac_q;
                            mul_r_d = dr;
                            mul_p_d = '0;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = S_MUL;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_ROT: begin
                if (ror_q) begin
                    ac_d = {e_q, ac_q[WIDTH-1:1]};
                    e_d  = ac_q[0];
                end else begin
                    ac_d = {ac_q[WIDTH-2:0], e_q};
                    e_d  = ac_q[WIDTH-1];
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                mul_p_d = mul_p_nxt;
                mul_r_d = mul_r_nxt;
                cnt_d   = cnt_q - CNT_W'(1);
                // Architectural registers only see the product on the last step.
                if (cnt_q == CNT_W'(1)) begin
                    ac_d    = mul_r_nxt;
                    mq_d    = mul_p_nxt;
                    e_d     = (mul_p_nxt != '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ac_q      <= '0;
            e_q       <= 1'b0;
            mq_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            ror_q     <= 1'b0;
            mul_m_q   <= '0;
            mul_p_q   <= '0;
            mul_r_q   <= '0;
        end else begin
            state_q   <= state_d;
            ac_q      <= ac_d;
            e_q       <= e_d;
            mq_q      <= mq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            ror_q     <= ror_d;
            mul_m_q   <= mul_m_d;
            mul_p_q   <= mul_p_d;
            mul_r_q   <= mul_r_d;
        end
    end

    assign ac      = ac_q;
    assign e       = e_q;
    assign mq      = mq_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign zero    = (ac_q == '0);
    assign neg     = ac_q[WIDTH-1];

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq (WIDTH=16) with hand-computed expectations.
module tb_acc_alu_seq;

    localparam int unsigned W = 16;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LDA  = 4'd2;
    localparam logic [3:0] OP_CIL  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_CLE  = 4'd9;
    localparam logic [3:0] OP_CME  = 4'd10;
    localparam logic [3:0] OP_RORN = 4'd11;
    localparam logic [3:0] OP_ROLN = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_RSV  = 4'd14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] dr = '0;
    logic [W-1:0] inpr = '0;
    logic [W-1:0] ac;
    logic         e;
    logic [W-1:0] mq;
    logic         busy;
    logic         done;
    logic         illegal;
    logic         zero;
    logic         neg;

    int n_chk  = 0;
    int n_pass = 0;

    acc_alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .dr      (dr),
        .inpr    (inpr),
        .ac      (ac),
        .e       (e),
        .mq      (mq),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .zero    (zero),
        .neg     (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op at the next negedge; returns just after its accept edge.
    task automatic op_go(input logic [3:0] o, input logic [W-1:0] d);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        dr    = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        // Asynchronous reset, checked mid-cycle before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ac", 32'(ac), 32'h0);
        chk("rst_e", 32'(e), 32'h0);
        chk("rst_mq", 32'(mq), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_neg", 32'(neg), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // ADD carry, back-to-back with LDA
        op_go(OP_LDA, 16'hFFFF);
        chk("lda_ac", 32'(ac), 32'hFFFF);
        chk("lda_done", 32'(done), 32'h1);
        chk("lda_busy", 32'(busy), 32'h0);
        op_go(OP_ADD, 16'h0001);
        chk("add_ac", 32'(ac), 32'h0000);
        chk("add_e", 32'(e), 32'h1);
        chk("add_zero", 32'(zero), 32'h1);
        chk("add_done", 32'(done), 32'h1);
        step();
        chk("add_done_drop", 32'(done), 32'h0);

        // CME / CIL / INC
        op_go(OP_CLE, 16'h0000);
        chk("cle_e", 32'(e), 32'h0);
        op_go(OP_CME, 16'h0000);
        chk("cme_e", 32'(e), 32'h1);
        op_go(OP_LDA, 16'h8000);
        chk("lda8000_neg", 32'(neg), 32'h1);
        op_go(OP_CIL, 16'h0000);
        chk("cil_ac", 32'(ac), 32'h0001);
        chk("cil_e", 32'(e), 32'h1);
        op_go(OP_LDA, 16'hFFFF);
        op_go(OP_INC, 16'h0000);
        chk("inc_ac", 32'(ac), 32'h0000);
        chk("inc_e", 32'(e), 32'h1);

        // ROR_N n=3 with a start attempted during busy
        op_go(OP_CLE, 16'h0000);
        op_go(OP_LDA, 16'h0001);
        op_go(OP_RORN, 16'h0003);
        chk("ror_e0_busy", 32'(busy), 32'h1);
        chk("ror_e0_done", 32'(done), 32'h0);
        chk("ror_e0_ac", 32'(ac), 32'h0001);
        @(negedge clk);
        start = 1'b1;
        op    = OP_LDA;
        dr    = 16'hAAAA;
        step();
        chk("ror_e1_ac", 32'({e, ac}), 32'h1_0000);
        chk("ror_e1_busy", 32'(busy), 32'h1);
        step();
        chk("ror_e2_ac", 32'({e, ac}), 32'h0_8000);
        chk("ror_e2_busy", 32'(busy), 32'h1);
        step();
        start = 1'b0;
        chk("ror_e3_ac", 32'({e, ac}), 32'h0_4000);
        chk("ror_e3_busy", 32'(busy), 32'h0);
        chk("ror_e3_done", 32'(done), 32'h1);
        step();
        chk("ror_ignored_ac", 32'(ac), 32'h4000);
        chk("ror_done_drop", 32'(done), 32'h0);

        // n=0 (upper dr bits outside the count field are ignored)
        op_go(OP_ROLN, 16'h0020);
        chk("rol0_done", 32'(done), 32'h1);
        chk("rol0_busy", 32'(busy), 32'h0);
        chk("rol0_ac", 32'({e, ac}), 32'h0_4000);

        // n=W+1 circulates the 17-bit ring back to its start
        op_go(OP_ROLN, 16'h0011);
        repeat (16) step();
        chk("rol17_busy16", 32'(busy), 32'h1);
        step();
        chk("rol17_done", 32'(done), 32'h1);
        chk("rol17_ac", 32'({e, ac}), 32'h0_4000);

        // MUL 0x1234 x 0x0010
        op_go(OP_LDA, 16'h1234);
        op_go(OP_MUL, 16'h0010);
        chk("mul_e0_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("mul_hold_ac_e%0d", i), 32'({busy, done, ac}), 32'h2_1234);
        end
        step();
        chk("mul_ac", 32'(ac), 32'h2340);
        chk("mul_mq", 32'(mq), 32'h0001);
        chk("mul_e", 32'(e), 32'h1);
        chk("mul_done", 32'(done), 32'h1);
        chk("mul_busy", 32'(busy), 32'h0);

        // Reserved op
        op_go(OP_RSV, 16'hFFFF);
        chk("rsv_done", 32'(done), 32'h1);
        chk("rsv_illegal", 32'(illegal), 32'h1);
        chk("rsv_state", 32'({e, mq, ac}), {15'h0, 1'b1, 16'h0001, 16'h2340});
        step();
        chk("rsv_illegal_drop", 32'({done, illegal}), 32'h0);

        // Reset abort mid-MUL
        op_go(OP_MUL, 16'h0003);
        repeat (7) step();
        chk("abort_busy", 32'(busy), 32'h1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("abort_ac", 32'(ac), 32'h0);
        chk("abort_mq", 32'(mq), 32'h0);
        chk("abort_e_busy_done", 32'({e, busy, done, illegal}), 32'h0);
        chk("abort_zero", 32'(zero), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        op_go(OP_LDA, 16'h5A5A);
        chk("post_abort_ac", 32'(ac), 32'h5A5A);
        chk("post_abort_done", 32'(done), 32'h1);

        // MUL 0x00FF x 0x0101
        op_go(OP_LDA, 16'h00FF);
        op_go(OP_MUL, 16'h0101);
        repeat (15) step();
        chk("mul2_hold", 32'(ac), 32'h00FF);
        step();
        chk("mul2_ac", 32'(ac), 32'hFFFF);
        chk("mul2_mq", 32'(mq), 32'h0000);
        chk("mul2_e", 32'(e), 32'h0);
        chk("mul2_done", 32'(done), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_alu_seq.md
# acc_alu_seq

Registered accumulator/ALU unit for the hardwired CPU datapath, parametrised in data width. It owns the AC, E (extend/carry) and MQ registers. It executes single-cycle logic, arithmetic and transfer ops, plus multi-cycle N-position circulates and an unsigned shift-add multiply. Ops are launched by the control sequencer with a start/busy/done handshake.

## Interface

- `WIDTH`, default 16, datapath width; legal range is 4 or more.
- `CW`, default `$clog2(WIDTH)+1`, width of the rotate count taken from `dr`.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: op request; accepted only when `busy`=0.
- `op` in 4: op code, sampled on the accept edge.
- `dr` in WIDTH: operand from DR, sampled on the accept edge.
- `inpr` in WIDTH: input register value, sampled on the accept edge.
- `ac` out WIDTH: accumulator.
- `e` out 1: extend/carry bit.
- `mq` out WIDTH: high half of the multiply product.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle completion pulse.
- `illegal` out 1: pulses with `done` for a reserved op code.
- `zero` out 1: combinational, `ac`==0.
- `neg` out 1: combinational, `ac[WIDTH-1]`.

## Operation

Op codes:
- 0 AND: ac&=dr.
- 1 ADD: {e,ac}=ac+dr, where e is the carry out.
- 2 LDA: ac=dr.
- 3 INP: ac=inpr.
- 4 CMA: ac=~ac.
- 5 CIR: ac={e,ac[W-1:1]}, e=ac[0].
- 6 CIL: ac={ac[W-2:0],e}, e=ac[W-1].
- 7 INC: ac=ac+1, modulo 2^W; e is unchanged.
- 8 CLA: ac=0.
- 9 CLE: e=0.
- 10 CME: e=~e.
- 11 ROR_N: CIR repeated n=dr[CW-1:0] times.
- 12 ROL_N: CIL repeated n times.
- 13 MUL: unsigned ac×dr. The low W bits go to ac, the high W bits go to mq, and e=(high half != 0).
- 14, 15: reserved. No state change; `illegal` pulses.

State machine, with states IDLE, ROT and MUL:
- IDLE, `start`=1: op is latched.
  - Single-cycle ops, reserved ops, and ROR_N/ROL_N with n=0 execute on that edge and stay in IDLE.
  - ROR_N/ROL_N with n>0: load the step counter with n and go to ROT.
  - MUL: latch the multiplicand (ac) and multiplier (dr), clear the internal high accumulator, load the counter with WIDTH, and go to MUL.
- ROT: each edge performs one circulate step, updating ac and e live, and decrements the counter. On the step that brings the counter to 0, go to IDLE.
- MUL: each edge computes {c,P}=P+(Q[0]?M:0), then shifts {c,P,Q} right by one and decrements the counter. On the final step, write ac=Q, mq=P and e=(P!=0), then go to IDLE. ac, e and mq hold their pre-op values until that final write.
- `start` while `busy`=1 is ignored. It is not queued and has no side effects.
- mq changes only on MUL completion and on reset.
- Reset in any state aborts immediately. All registers and outputs go to their reset values and the state returns to IDLE.

## Timing

- Reset values: ac=0, e=0, mq=0, busy=0, done=0, illegal=0, state=IDLE. Therefore zero=1 and neg=0 during reset.
- Accept edge = edge 0, when `start`=1 and `busy`=0.
- Single-cycle, reserved, and n=0 ops:
  - Results are visible after edge 0.
  - done=1 (and illegal, if applicable) for exactly the cycle following edge 0.
  - busy stays 0.
  - A new `start` may be accepted on edge 1, which allows back-to-back ops at one per cycle.
- ROR_N/ROL_N with n>0:
  - busy=1 after edge 0.
  - Steps occur on edges 1..n.
  - At edge n, busy goes to 0 and done goes to 1 for one cycle.
  - Total latency is n+1 edges.
- MUL:
  - busy=1 after edge 0.
  - Steps occur on edges 1..WIDTH, with the result written at edge WIDTH.
  - done is pulsed after edge WIDTH.
  - Total latency is WIDTH+1 edges.
- done and busy are never high together.
- Arithmetic wrap-around:
  - ADD overflow is kept only via e.
  - INC wraps 0xFFFF to 0x0000 with e untouched.
  - A rotate count n larger than W+1 is legal and simply circulates the W+1-bit ring n times.

## Test plan

All scenarios use WIDTH=16.

- **Reset:** assert rst_n=0 mid-cycle. Required: ac=0, e=0, mq=0, busy=0, done=0, zero=1 immediately (asynchronous).
- **ADD carry:** LDA dr=0xFFFF, then ADD dr=0x0001. Required: ac=0x0000, e=1, zero=1, done high one cycle after each accept, and the ops run back-to-back with no idle cycle.
- **CIL / INC:** CME to set e=1, LDA 0x8000, CIL. Required: ac=0x0001, e=1. Then INC on 0xFFFF. Required: ac=0x0000 with e unchanged.
- **ROR_N, n=3:** start from ac=0x0001, e=0. Required: ac/e step through 0x0000/1, 0x8000/0 and 0x4000/0 on edges 1–3, busy for 3 cycles, done after edge 3. A `start` issued during busy is ignored. n=0 gives done after edge 0 with no change.
- **MUL:** ac=0x1234 × dr=0x0010. Required: ac=0x2340, mq=0x0001, e=1, done after edge 16, and ac unchanged during edges 1–15. Also 0x00FF × 0x0101 gives ac=0xFFFF, mq=0, e=0.
- **Abort / reserved:** reset at edge 8 of a MUL. Required: all registers are at reset values and a new op is accepted next cycle. op=14 gives done=illegal=1 for one cycle with ac/e/mq unchanged.
